// File: rtl/bht_update_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bht_update_ctrl_if                                           |
// | Description : Bundle of IF1 lookup, EX resolve and pattern-table write     |
// |               signals for the gshare history/update controller.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bht_update_ctrl_if #(
    parameter int BHR_WIDTH = 4
);
    // IF1 side
    logic                 if1_valid;
    logic [31:0]          if1_pc;
    logic                 pred_taken;
    logic                 if1_ready;
    logic [BHR_WIDTH-1:0] fbhr;
    // EX side and flush
    logic                 ex_valid;
    logic                 ex_taken;
    logic                 flush;
    // Pattern-table write port
    logic                 we;
    logic [31:0]          ex_pc;
    logic [BHR_WIDTH-1:0] wbhr;
    logic                 branched;
    logic                 mispredict;

    // Pipeline side: drives lookups, resolves and flushes
    modport master (
        output if1_valid, if1_pc, pred_taken, ex_valid, ex_taken, flush,
        input  if1_ready, fbhr, we, ex_pc, wbhr, branched, mispredict
    );

    // Controller side
    modport slave (
        input  if1_valid, if1_pc, pred_taken, ex_valid, ex_taken, flush,
        output if1_ready, fbhr, we, ex_pc, wbhr, branched, mispredict
    );
endinterface
`default_nettype wire

// File: rtl/bht_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bht_update_ctrl                                              |
// | Description : Speculative global history and in-order in-flight branch     |
// |               queue for a gshare predictor; generates the pattern-table    |
// |               update and recovers history on mispredict or flush.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bht_update_ctrl #(
    parameter int BHR_WIDTH = 4,
    parameter int DEPTH     = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bht_update_ctrl_if.slave  bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    // In-flight queue storage: {pc, history snapshot, prediction}
    logic [31:0]          r_q_pc  [DEPTH];
    logic [BHR_WIDTH-1:0] r_q_bhr [DEPTH];
    logic [DEPTH-1:0]     r_q_pred;

    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic [BHR_WIDTH-1:0] r_fbhr;
    logic [BHR_WIDTH-1:0] r_abhr;
    logic [BHR_WIDTH-1:0] r_wbhr;
    logic [31:0]          r_ex_pc;
    logic                 r_we;
    logic                 r_branched;
    logic                 r_mispredict;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_resolve;
    logic                 w_mis;
    logic                 w_accept;
    logic [BHR_WIDTH-1:0] w_resolved_hist;

    // Ready depends on occupancy alone so IF1 never sees a combinational
    // path from the EX side; a same-cycle pop is not credited.
    assign w_ready   = (r_count != c_FULL);
    assign w_push    = bus.if1_valid && w_ready;
    // Flush kills any resolve in the same cycle; empty-queue resolves are ignored.
    assign w_resolve = bus.ex_valid && (r_count != '0) && !bus.flush;
    assign w_mis     = w_resolve && (bus.ex_taken != r_q_pred[r_head]);
    // A push is dropped when the cycle also recovers history (wrong path).
    assign w_accept  = w_push && !bus.flush && !w_mis;
    // History as it should have been after the oldest branch: its snapshot
    // shifted by the real outcome.
    assign w_resolved_hist = {r_q_bhr[r_head][BHR_WIDTH-2:0], bus.ex_taken};

    // Queue payload write; contents need no reset since count gates their use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_pc[r_tail]   <= bus.if1_pc;
            r_q_bhr[r_tail]  <= r_fbhr;
            r_q_pred[r_tail] <= bus.pred_taken;
        end
    end

    // Pointers, histories and the registered pattern-table update port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fbhr       <= '0;
            r_abhr       <= '0;
            r_wbhr       <= '0;
            r_ex_pc      <= '0;
            r_we         <= 1'b0;
            r_branched   <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_we         <= w_resolve;
            r_mispredict <= w_mis;
            if (w_resolve) begin
                r_ex_pc    <= r_q_pc[r_head];
                r_wbhr     <= r_q_bhr[r_head];
                r_branched <= bus.ex_taken;
                r_abhr     <= w_resolved_hist;
            end
            if (bus.flush) begin
                // Everything in flight is dead; fall back to committed history
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_fbhr  <= r_abhr;
            end else if (w_mis) begin
                // Younger entries were fetched down the wrong path
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_fbhr  <= w_resolved_hist;
            end else begin
                if (w_accept) begin
                    r_tail <= r_tail + 1'b1;
                    r_fbhr <= {r_fbhr[BHR_WIDTH-2:0], bus.pred_taken};
                end
                if (w_resolve) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_resolve);
            end
        end
    end

    assign bus.if1_ready  = w_ready;
    assign bus.fbhr       = r_fbhr;
    assign bus.we         = r_we;
    assign bus.ex_pc      = r_ex_pc;
    assign bus.wbhr       = r_wbhr;
    assign bus.branched   = r_branched;
    assign bus.mispredict = r_mispredict;

endmodule
`default_nettype wire

// File: tb/tb_bht_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bht_update_ctrl                                           |
// | Description : Self-checking bench for bht_update_ctrl: directed scenarios  |
// |               plus random traffic against a queue-based reference model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bht_update_ctrl;

    localparam int BW    = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    bht_update_ctrl_if #(.BHR_WIDTH(BW)) bus ();

    bht_update_ctrl #(.BHR_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [31:0] pc;
        int          bhr;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    int          m_fbhr, m_abhr, m_wbhr;
    logic [31:0] m_ex_pc;
    logic        m_we, m_br, m_mis;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fbhr = 0; m_abhr = 0; m_wbhr = 0;
        m_ex_pc = '0; m_we = 1'b0; m_br = 1'b0; m_mis = 1'b0;
    endtask

    // Apply one clock of the controller's rules to the model
    task automatic model_step(input logic v, input logic [31:0] pc, input logic pr,
                              input logic exv, input logic ext, input logic fl);
        logic push;
        ent_t h;
        ent_t e;
        push  = v && (mq.size() < DEPTH);
        m_we  = 1'b0;
        m_mis = 1'b0;
        if (fl) begin
            mq.delete();
            m_fbhr = m_abhr;
        end else begin
            if (exv && mq.size() > 0) begin
                h       = mq.pop_front();
                m_we    = 1'b1;
                m_ex_pc = h.pc;
                m_wbhr  = h.bhr;
                m_br    = ext;
                m_abhr  = ((h.bhr * 2) + int'(ext)) % (1 << BW);
                if (ext != h.pred) begin
                    m_mis = 1'b1;
                    mq.delete();
                    m_fbhr = m_abhr;
                    push   = 1'b0;
                end
            end
            if (push) begin
                e.pc = pc; e.bhr = m_fbhr; e.pred = pr;
                mq.push_back(e);
                m_fbhr = ((m_fbhr * 2) + int'(pr)) % (1 << BW);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fbhr"},  32'(bus.fbhr),       32'(m_fbhr));
        chk({tag, ".we"},    32'(bus.we),         32'(m_we));
        chk({tag, ".mis"},   32'(bus.mispredict), 32'(m_mis));
        chk({tag, ".expc"},  bus.ex_pc,           m_ex_pc);
        chk({tag, ".wbhr"},  32'(bus.wbhr),       32'(m_wbhr));
        chk({tag, ".br"},    32'(bus.branched),   32'(m_br));
        chk({tag, ".ready"}, 32'(bus.if1_ready),  32'(mq.size() != DEPTH));
    endtask

    // One clock: drive, check ready before the edge, advance model, check after
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic pr, input logic exv, input logic ext, input logic fl);
        bus.if1_valid  = v;
        bus.if1_pc     = pc;
        bus.pred_taken = pr;
        bus.ex_valid   = exv;
        bus.ex_taken   = ext;
        bus.flush      = fl;
        #1;
        chk({tag, ".ready_pre"}, 32'(bus.if1_ready), 32'(mq.size() != DEPTH));
        model_step(v, pc, pr, exv, ext, fl);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.if1_valid = 1'b0; bus.if1_pc = '0; bus.pred_taken = 1'b0;
        bus.ex_valid  = 1'b0; bus.ex_taken = 1'b0; bus.flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single push then correct taken resolve
        step("p1", 1'b1, 32'h1C000010, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("p1.fbhr_const", 32'(bus.fbhr), 32'h1);
        step("r1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("r1.expc_const", bus.ex_pc, 32'h1C000010);
        chk("r1.we_const", 32'(bus.we), 32'h1);
        idle("r1_idle");
        chk("r1.we_drop", 32'(bus.we), 32'h0);

        // Three pushes then mispredict on the oldest
        async_reset("rst2");
        step("m_p0", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step("m_p1", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        step("m_p2", 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("m.fbhr7", 32'(bus.fbhr), 32'h7);
        step("m_res", 1'b1, 32'h10C, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("m.mis_const", 32'(bus.mispredict), 32'h1);
        chk("m.fbhr0", 32'(bus.fbhr), 32'h0);
        step("m_empty_ex", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("m.no_we", 32'(bus.we), 32'h0);

        // Fill to DEPTH, overflow attempt, then one pop
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1'b1, 32'h200 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0, 1'b0);
        chk("full.ready", 32'(bus.if1_ready), 32'h0);
        step("overflow", 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        step("full_pop", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pop.ready", 32'(bus.if1_ready), 32'h1);

        // Two entries held, then push and correct pop together
        async_reset("rst3");
        step("s_p0", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        step("s_p1", 1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        step("s_both", 1'b1, 32'h408, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s.fbhr", 32'(bus.fbhr), 32'h5);
        step("s_d0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("s_d1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("s_d2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s.drained_we", 32'(bus.we), 32'h0);

        // Committed history restored on flush
        async_reset("rst4");
        step("f_p0", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        step("f_p1", 1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0);
        step("f_r0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("f_r1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("f_p2", 1'b1, 32'h508, 1'b0, 1'b0, 1'b0, 1'b0);
        step("f_p3", 1'b1, 32'h50C, 1'b0, 1'b0, 1'b0, 1'b0);
        step("f_flush", 1'b1, 32'h510, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("f.fbhr3", 32'(bus.fbhr), 32'h3);
        chk("f.no_we", 32'(bus.we), 32'h0);
        step("f_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("f.empty", 32'(bus.we), 32'h0);

        // Pointer wrap with steady push/pop, then reset mid-run
        for (int i = 0; i < 20; i++)
            step("wrap", 1'b1, 32'h600 + 32'(i * 4), 1'b1, (i > 1), 1'b1, 1'b0);
        async_reset("rst_mid");
        chk("rst_mid.ready", 32'(bus.if1_ready), 32'h1);
        step("post_rst_push", 1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic; outcomes mostly agree with the head prediction
        for (int i = 0; i < 400; i++) begin
            logic v, pr, exv, ext, fl;
            v   = ($urandom_range(0, 9) < 6);
            pr  = 1'($urandom);
            exv = ($urandom_range(0, 9) < 5);
            fl  = ($urandom_range(0, 49) == 0);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) ext = mq[0].pred;
            else ext = 1'($urandom);
            step("rand", v, $urandom, pr, exv, ext, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
